// File: rtl/symbol_mode_pkg.sv
// Shared types and constants for the 2-bit symbol histogram/mode controller.
// The optional abort path is controlled by the SMC_ABORT_EN macro.
package symbol_mode_pkg;

  localparam int unsigned NUM_SYM = 4;
  localparam int unsigned SYM_W   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/symbol_mode_ctrl_if.sv
// Handshake, status and result bundle for symbol_mode_ctrl.
// With SMC_ABORT_EN defined an abort request line is added.
interface symbol_mode_ctrl_if #(
  parameter int unsigned CNT_W = 4
) ();
  import symbol_mode_pkg::*;

  logic             start;
  logic             in_valid;
  logic [SYM_W-1:0] in_data;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] cnt2;
  logic [CNT_W-1:0] cnt3;
  logic [SYM_W-1:0] max_data;
`ifdef SMC_ABORT_EN
  logic             abort;

  modport master (
    output start, in_valid, in_data, abort,
    input  in_ready, busy, done, cnt0, cnt1, cnt2, cnt3, max_data
  );

  modport slave (
    input  start, in_valid, in_data, abort,
    output in_ready, busy, done, cnt0, cnt1, cnt2, cnt3, max_data
  );
`else
  modport master (
    output start, in_valid, in_data,
    input  in_ready, busy, done, cnt0, cnt1, cnt2, cnt3, max_data
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, busy, done, cnt0, cnt1, cnt2, cnt3, max_data
  );
`endif

endinterface

// File: rtl/symbol_mode_cmp.sv
// Single step of the serial mode search. Step 0 seeds the running best;
// later steps take over only on a strictly larger count, so ties keep the
// lowest symbol value.
module symbol_mode_cmp
  import symbol_mode_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic [CNT_W-1:0] cnt_in,
  input  logic [SYM_W-1:0] idx,
  input  logic [CNT_W-1:0] best_cnt,
  input  logic [SYM_W-1:0] best_idx,
  output logic [CNT_W-1:0] nxt_best_cnt,
  output logic [SYM_W-1:0] nxt_best_idx
);

  // Seed on idx 0, otherwise replace only on strictly greater count
  always_comb begin
    nxt_best_cnt = best_cnt;
    nxt_best_idx = best_idx;
    if ((idx == '0) || (cnt_in > best_cnt)) begin
      nxt_best_cnt = cnt_in;
      nxt_best_idx = idx;
    end
  end

endmodule

// File: rtl/symbol_mode_ctrl.sv
// Symbol histogram front-end and mode scheduler. Accepts WIN 2-bit symbols
// over valid/ready, counts each value, then walks the four counts serially
// to find the most frequent value and pulses done for one cycle.
// Optional abort request compiled in with SMC_ABORT_EN.
module symbol_mode_ctrl
  import symbol_mode_pkg::*;
#(
  parameter int unsigned WIN   = 8,
  parameter int unsigned CNT_W = 4
) (
  input logic               clk,
  input logic               rst,
  symbol_mode_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] WinLast = CNT_W'(WIN - 1);
  localparam logic [SYM_W-1:0] IdxLast = SYM_W'(NUM_SYM - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NUM_SYM];
  logic [CNT_W-1:0] sym_cnt_q;
  logic [SYM_W-1:0] max_q;
  logic [SYM_W-1:0] idx_q;
  logic [CNT_W-1:0] best_cnt_q, nxt_best_cnt;
  logic [SYM_W-1:0] best_idx_q, nxt_best_idx;
  logic             xfer;
  logic             clear;
  logic             abort_hit;

`ifdef SMC_ABORT_EN
  assign abort_hit = bus.abort && ((state_q == ACCUM) || (state_q == RESOLVE));
`else
  assign abort_hit = 1'b0;
`endif

  // Next-state decode; abort overrides everything, including a final transfer
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    xfer    = (state_q == ACCUM) && bus.in_valid;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          clear   = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (xfer && (sym_cnt_q == WinLast)) state_d = RESOLVE;
      end
      RESOLVE: begin
        if (idx_q == IdxLast) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort_hit) begin
      state_d = IDLE;
      clear   = 1'b1;
      xfer    = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Per-value counts and window length; cleared on start or abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SYM; i++) cnt_q[i] <= '0;
      sym_cnt_q <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_SYM; i++) cnt_q[i] <= '0;
      sym_cnt_q <= '0;
    end else if (xfer) begin
      cnt_q[bus.in_data] <= cnt_q[bus.in_data] + 1'b1;
      sym_cnt_q          <= sym_cnt_q + 1'b1;
    end
  end

  symbol_mode_cmp #(
    .CNT_W (CNT_W)
  ) u_cmp (
    .cnt_in       (cnt_q[idx_q]),
    .idx          (idx_q),
    .best_cnt     (best_cnt_q),
    .best_idx     (best_idx_q),
    .nxt_best_cnt (nxt_best_cnt),
    .nxt_best_idx (nxt_best_idx)
  );

  // Serial compare walk; max_data only moves at the end of the walk or on a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      best_cnt_q <= '0;
      best_idx_q <= '0;
      max_q      <= '0;
    end else begin
      if ((state_q == RESOLVE) && (state_d == RESOLVE)) begin
        idx_q <= idx_q + 1'b1;
      end else begin
        idx_q <= '0;
      end
      if (state_q == RESOLVE) begin
        best_cnt_q <= nxt_best_cnt;
        best_idx_q <= nxt_best_idx;
      end
      if (clear) begin
        max_q <= '0;
      end else if ((state_q == RESOLVE) && (state_d == DONE)) begin
        max_q <= nxt_best_idx;
      end
    end
  end

  assign bus.in_ready = (state_q == ACCUM);
  assign bus.busy     = (state_q == ACCUM) || (state_q == RESOLVE);
  assign bus.done     = (state_q == DONE);
  assign bus.cnt0     = cnt_q[0];
  assign bus.cnt1     = cnt_q[1];
  assign bus.cnt2     = cnt_q[2];
  assign bus.cnt3     = cnt_q[3];
  assign bus.max_data = max_q;

endmodule
